regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 90 +++++++++
 tb/tb_regfile_sb.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: two-read, one-write register file with a per-register busy scoreboard.
// Reads and busy lookups are combinational; data, busy bits and PENDING update on clk.
module regfile_sb #(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            WE3,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic            ISSUE,
    input  logic [AW-1:0]   IA,
    output logic            BUSY1,
    output logic            BUSY2,
    output logic [AW:0]     PENDING
);

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_n;
    logic [AW:0]      pending;
    logic [AW:0]      pending_n;
    logic             we_ok;
    logic             issue_ok;
    logic             inc;
    logic             dec;

    assign we_ok    = WE3 && !(ZERO_REG != 0 && A3 == '0);
    assign issue_ok = ISSUE && !(ZERO_REG != 0 && IA == '0);

    // A same-cycle issue overrides the clear: the newest producer owns the register.
    always_comb begin
        busy_n = busy;
        if (we_ok)
            busy_n[A3] = 1'b0;
        if (issue_ok)
            busy_n[IA] = 1'b1;
    end

    assign inc = issue_ok && !busy[IA];
    assign dec = we_ok && busy[A3] && !(issue_ok && IA == A3);

    assign pending_n = pending + (AW+1)'(inc) - (AW+1)'(dec);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
            busy    <= '0;
            pending <= '0;
        end else begin
            if (we_ok)
                regs[A3] <= WD3;
            busy    <= busy_n;
            pending <= pending_n;
        end
    end

    function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] a);
        if (!reset || (ZERO_REG != 0 && a == '0))
            return '0;
        if (BYPASS != 0 && we_ok && A3 == a)
            return WD3;
        return regs[a];
    endfunction

    // Forwarded data lets the consumer proceed unless a new producer issues now.
    function automatic logic busy_port(input logic [AW-1:0] a);
        if (!reset)
            return 1'b0;
        if (BYPASS != 0 && we_ok && A3 == a && !(issue_ok && IA == a))
            return 1'b0;
        return busy[a];
    endfunction

    assign RD1     = rd_port(A1);
    assign RD2     = rd_port(A2);
    assign BUSY1   = busy_port(A1);
    assign BUSY2   = busy_port(A2);
    assign PENDING = pending;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb (bypass and non-bypass)
// against an array-based reference model.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic        ISSUE;
    logic [4:0]  IA;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        bsy1_b, bsy2_b, bsy1_n, bsy2_n;
    logic [5:0]  pend_b, pend_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs [32];
    bit          mbusy [32];

    regfile_sb dut (
        .clk(clk), .reset(reset), .WE3(WE3), .A3(A3), .WD3(WD3),
        .A1(A1), .A2(A2), .RD1(rd1_b), .RD2(rd2_b),
        .ISSUE(ISSUE), .IA(IA), .BUSY1(bsy1_b), .BUSY2(bsy2_b),
        .PENDING(pend_b)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .WE3(WE3), .A3(A3), .WD3(WD3),
        .A1(A1), .A2(A2), .RD1(rd1_n), .RD2(rd2_n),
        .ISSUE(ISSUE), .IA(IA), .BUSY1(bsy1_n), .BUSY2(bsy2_n),
        .PENDING(pend_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) begin
            mregs[i] = '0;
            mbusy[i] = 1'b0;
        end
    endfunction

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
        if (!reset || a == 0)
            return '0;
        if (byp && WE3 && A3 == a)
            return WD3;
        return mregs[a];
    endfunction

    function automatic logic [31:0] exp_bsy(input bit byp, input logic [4:0] a);
        if (!reset)
            return '0;
        if (byp && WE3 && A3 == a && !(ISSUE && IA == a))
            return '0;
        return {31'b0, mbusy[a]};
    endfunction

    function automatic logic [31:0] exp_pend();
        int n = 0;
        for (int i = 0; i < 32; i++)
            n += int'(mbusy[i]);
        return n;
    endfunction

    function automatic void model_edge();
        if (!reset)
            return;
        if (WE3 && A3 != 0) begin
            mregs[A3] = WD3;
            mbusy[A3] = 1'b0;
        end
        if (ISSUE && IA != 0)
            mbusy[IA] = 1'b1;
    endfunction

    task automatic check_comb(input string tag);
        chk({tag, "_rd1_b"}, rd1_b, exp_rd(1, A1));
        chk({tag, "_rd2_b"}, rd2_b, exp_rd(1, A2));
        chk({tag, "_rd1_n"}, rd1_n, exp_rd(0, A1));
        chk({tag, "_rd2_n"}, rd2_n, exp_rd(0, A2));
        chk({tag, "_bsy1_b"}, {31'b0, bsy1_b}, exp_bsy(1, A1));
        chk({tag, "_bsy2_b"}, {31'b0, bsy2_b}, exp_bsy(1, A2));
        chk({tag, "_bsy1_n"}, {31'b0, bsy1_n}, exp_bsy(0, A1));
        chk({tag, "_bsy2_n"}, {31'b0, bsy2_n}, exp_bsy(0, A2));
    endtask

    // Inputs are driven just after a rising edge; comb outputs are checked
    // mid-cycle, the edge is applied to the model, then PENDING is checked.
    task automatic cyc(input string tag);
        #2;
        check_comb(tag);
        @(posedge clk);
        model_edge();
        #1;
        chk({tag, "_pend_b"}, {26'b0, pend_b}, exp_pend());
        chk({tag, "_pend_n"}, {26'b0, pend_n}, exp_pend());
    endtask

    task automatic idle();
        WE3 = 0; ISSUE = 0; A3 = 0; IA = 0; WD3 = 0;
    endtask

    initial begin
        reset = 0;
        idle();
        A1 = 5; A2 = 31;
        model_clear();

        // activity under reset is discarded and reads stay 0
        WE3 = 1; A3 = 5; WD3 = 32'hAAAA_5555;
        ISSUE = 1; IA = 9; A1 = 5; A2 = 9;
        cyc("in_reset");
        chk("in_reset_rd1_const", rd1_b, 32'h0);
        reset = 1;

        idle();
        A1 = 5; A2 = 31;
        cyc("post_reset");
        chk("post_reset_pend", {26'b0, pend_b}, 32'h0);

        WE3 = 1; A3 = 0; WD3 = 32'hDEAD_BEEF; A1 = 0; A2 = 0;
        cyc("zero_wr");
        chk("zero_after", rd1_b, 32'h0);

        WE3 = 1; A3 = 2; WD3 = 32'h2; A1 = 2;
        cyc("wr2");
        WE3 = 0; WD3 = 32'h12; A1 = 2;
        cyc("hold2");
        chk("reg2_const", rd1_b, 32'h2);

        WE3 = 1; A3 = 7; WD3 = 32'h12; A2 = 7;
        #2;
        chk("byp_rd2_const", rd2_b, 32'h12);
        chk("nobyp_rd2_const", rd2_n, 32'h0);
        cyc("byp7");
        idle(); A2 = 7;
        #2;
        chk("nobyp_after_const", rd2_n, 32'h12);
        cyc("after7");

        ISSUE = 1; IA = 3; A1 = 3;
        cyc("iss3");
        ISSUE = 1; IA = 3;
        #2;
        chk("busy3_const", {31'b0, bsy1_b}, 32'h1);
        cyc("iss3_again");
        chk("pend_one_const", {26'b0, pend_b}, 32'h1);
        ISSUE = 1; IA = 4; WE3 = 1; A3 = 3; WD3 = 32'h33; A1 = 3; A2 = 4;
        cyc("wr3_iss4");
        idle(); A1 = 3; A2 = 4;
        cyc("chk34");
        chk("pend_34_const", {26'b0, pend_b}, 32'h1);

        ISSUE = 1; IA = 6; WE3 = 1; A3 = 6; WD3 = 32'h66; A1 = 6;
        cyc("iss_wr6");
        idle(); A1 = 6;
        #2;
        chk("busy6_const", {31'b0, bsy1_b}, 32'h1);
        chk("rd6_const", rd1_b, 32'h66);
        cyc("chk6");

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0) begin
                reset = 0;
                model_clear();
                #1;
                chk("rnd_async_pend", {26'b0, pend_b}, 32'h0);
            end
            WE3 = 1'($urandom_range(0, 1));
            A3 = 5'($urandom);
            WD3 = $urandom;
            ISSUE = 1'($urandom_range(0, 1));
            IA = 5'($urandom);
            A1 = ($urandom_range(0, 3) == 0) ? A3 : 5'($urandom);
            A2 = ($urandom_range(0, 3) == 0) ? IA : 5'($urandom);
            cyc("rnd");
            reset = 1;
        end

        idle();
        for (int r = 1; r < 32; r++) begin
            ISSUE = 1; IA = 5'(r);
            cyc("fill");
        end
        idle(); A1 = 5; A2 = 31;
        chk("fill_pend_const", {26'b0, pend_b}, 32'd31);
        #3;
        reset = 0;
        model_clear();
        #1;
        chk("rst_pend_const", {26'b0, pend_b}, 32'h0);
        chk("rst_pend_n_const", {26'b0, pend_n}, 32'h0);
        chk("rst_bsy1_const", {31'b0, bsy1_b}, 32'h0);
        chk("rst_bsy2_const", {31'b0, bsy2_b}, 32'h0);
        chk("rst_rd1_const", rd1_b, 32'h0);
        #2;
        reset = 1;
        #1;
        chk("rel_bsy2", {31'b0, bsy2_b}, exp_bsy(1, A2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
